start_change_udp_formatter: RTL and testbench
=============================================

# start_change_udp_formatter

Downstream of the StartChange broadcast sequencer: converts each per-replica send request (meta handshake, then one data beat) into a UDP TX transaction. The UDP TX transaction consists of one metadata beat carrying source/destination addressing and length, followed by the serialized StartChange message on a DATA_W bus. The destination endpoint is latched from the config RAM read response when the sequencer pulses `store_config_ram_rd`. View and replica index are snapshotted when the request is accepted.

## Interface
Parameters:
- DATA_W, 64, UDP TX data width in bits; legal values 64/128/256/512.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- src_ip  in  32  local IP; static
- src_port  in  16  local UDP port; static
- curr_view  in  64  current view number
- my_index  in  32  local replica index
- config_ram_rd_resp_data  in  48  config RAM read response, {ip[47:16], port[15:0]}
- store_config_ram_rd  in  1  latch config_ram_rd_resp_data this cycle
- start_change_to_udp_meta_val  in  1  request meta valid
- to_udp_start_change_meta_rdy  out  1  request meta ready
- start_change_to_udp_data_val  in  1  request data valid
- start_change_to_udp_data_last  in  1  request data last; always 1 by contract
- to_udp_start_change_data_rdy  out  1  request data ready
- udp_tx_meta_val  out  1  UDP metadata valid
- udp_tx_meta_src_ip / udp_tx_meta_dst_ip  out  32  IP addresses
- udp_tx_meta_src_port / udp_tx_meta_dst_port  out  16  UDP ports
- udp_tx_meta_len  out  16  payload bytes; constant SC_MSG_BYTES = 16
- udp_tx_meta_rdy  in  1  UDP metadata ready
- udp_tx_data_val  out  1  UDP data valid
- udp_tx_data  out  DATA_W  payload flit; byte 0 in MSBs
- udp_tx_data_last  out  1  final flit
- udp_tx_data_padbytes  out  clog2(DATA_W/8)  invalid trailing bytes in the last flit; 0 otherwise
- udp_tx_data_rdy  in  1  UDP data ready

## Operation
- Message layout: 16 bytes, big-endian.
  - Bytes 0-3: SC_MSG_TYPE.
  - Bytes 4-11: view.
  - Bytes 12-15: replica index.
- Flit count: NUM_FLITS = ceil(16/(DATA_W/8)).
  - DATA_W=64: 2 flits, padbytes 0.
  - DATA_W≥128: 1 flit, padbytes = DATA_W/8 − 16.
  - Unused low bytes are driven 0.
- Destination registers load on any cycle with `store_config_ram_rd`=1, in any state. The last load wins.
- State machine:
  - IDLE: `to_udp_start_change_meta_rdy`=1. On meta_val: snapshot curr_view and my_index → DATA_IN.
  - DATA_IN: `to_udp_start_change_data_rdy`=1. On data_val → OUT_META. `data_last` is ignored; each request is exactly one beat.
  - OUT_META: `udp_tx_meta_val`=1; meta fields come from the registers. On rdy: flit_cnt←0 → OUT_DATA.
  - OUT_DATA: `udp_tx_data_val`=1 and `udp_tx_data` = message slice flit_cnt.
    - On rdy with flit_cnt = NUM_FLITS−1 → IDLE.
    - On rdy otherwise: flit_cnt+1.
- Undefined states drive X and the next state X.
- All valid/ready outputs are pure decodes of the state register.
- The snapshot is stable from acceptance until return to IDLE. Changes to curr_view or my_index mid-message do not alter the payload.

## Timing
- Reset values:
  - state = IDLE, flit_cnt = 0.
  - Snapshot and destination registers = 0.
  - First cycle after reset: meta_rdy=1; data_rdy, udp_tx_meta_val and udp_tx_data_val all 0.
- Minimum latency: request meta accepted at T → data accepted at T+1 → udp meta valid at T+2 → first flit valid at T+3 if udp meta accepted at T+2.
- Throughput: one message per 3+NUM_FLITS cycles with zero backpressure.
- A valid, once asserted, holds with stable data until the matching rdy. No combinational path from any rdy input to any valid output.
- Simultaneous `store_config_ram_rd` and udp meta handshake: the outgoing beat carries the old destination; the new value applies to the next message.
- Reset mid-message: the message is abandoned, no partial flits follow, and the FSM returns to IDLE.

## Structure
- beehive_vr_pkg additions:
  - SC_MSG_TYPE (32'h0000_0005)
  - SC_MSG_BYTES
  - the sc_msg_hdr_t packed struct {type, view, replica_idx}
  - the config_entry_t struct {ip, port}
- No sub-module; the flit slicer is an indexed part-select inside this block.

## Test plan
- Single message, DATA_W=64:
  - Stimulus: config=0x0A000002/0x1F90, view=7, my_index=1, no backpressure.
  - Response: udp meta dst 10.0.0.2:8080, len 16. Flit0 = 0x00000005_00000000. Flit1 = 0x00000007_00000001 with last=1, padbytes=0.
- DATA_W=256:
  - Stimulus: same message as above.
  - Response: one flit, last=1, padbytes=16, low 16 bytes zero.
- Backpressure:
  - Stimulus: udp_tx_meta_rdy low for 5 cycles, udp_tx_data_rdy toggling.
  - Response: val and data held stable; each flit is emitted exactly once.
- curr_view changes from 7 to 8 after request accept.
  - Response: payload carries view 7.
- store_config_ram_rd during OUT_META for the next replica.
  - Response: current meta keeps the old dst; the next message uses the new dst.
- rst asserted in OUT_DATA after flit0.
  - Response: no flit1; meta_rdy=1 next cycle; a subsequent message is correct.

Source files
------------

// File: rtl/beehive_vr_pkg.sv
// Shared types and constants for the VR (viewstamped replication) datapath.
// Holds the StartChange message layout, the config RAM entry layout and the
// state encoding of the StartChange UDP formatter.
package beehive_vr_pkg;

    // Message type tag carried in the first word of a StartChange message.
    localparam logic [31:0] SC_MSG_TYPE  = 32'h0000_0005;
    // Serialized StartChange message length in bytes.
    localparam int unsigned SC_MSG_BYTES = 16;

    // Big-endian wire layout: msg_type lands in bytes 0-3.
    typedef struct packed {
        logic [31:0] msg_type;
        logic [63:0] view;
        logic [31:0] replica_idx;
    } sc_msg_hdr_t;

    // Config RAM read response layout.
    typedef struct packed {
        logic [31:0] ip;
        logic [15:0] port;
    } config_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StDataIn,
        StOutMeta,
        StOutData
    } sc_fmt_state_e;

endpackage

// File: rtl/start_change_udp_formatter.sv
// StartChange UDP formatter.
// Turns each per-replica send request from the StartChange broadcast sequencer
// (one meta handshake, then one data beat) into a UDP TX transaction: one
// metadata beat followed by the 16-byte StartChange message, serialized onto a
// DATA_W bus with byte 0 in the MSBs.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   src_ip, src_port             static local addressing
//   curr_view, my_index          snapshotted when a request is accepted
//   config_ram_rd_resp_data      {ip, port} destination, latched on store_config_ram_rd
//   start_change_to_udp_*        request meta/data handshakes from the sequencer
//   udp_tx_meta_*                outgoing UDP metadata beat
//   udp_tx_data_*                outgoing payload flits
module start_change_udp_formatter
    import beehive_vr_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    localparam int unsigned PAD_W = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [31:0]       src_ip,
    input  logic [15:0]       src_port,
    input  logic [63:0]       curr_view,
    input  logic [31:0]       my_index,

    input  logic [47:0]       config_ram_rd_resp_data,
    input  logic              store_config_ram_rd,

    input  logic              start_change_to_udp_meta_val,
    output logic              to_udp_start_change_meta_rdy,
    input  logic              start_change_to_udp_data_val,
    input  logic              start_change_to_udp_data_last,
    output logic              to_udp_start_change_data_rdy,

    output logic              udp_tx_meta_val,
    output logic [31:0]       udp_tx_meta_src_ip,
    output logic [31:0]       udp_tx_meta_dst_ip,
    output logic [15:0]       udp_tx_meta_src_port,
    output logic [15:0]       udp_tx_meta_dst_port,
    output logic [15:0]       udp_tx_meta_len,
    input  logic              udp_tx_meta_rdy,

    output logic              udp_tx_data_val,
    output logic [DATA_W-1:0] udp_tx_data,
    output logic              udp_tx_data_last,
    output logic [PAD_W-1:0]  udp_tx_data_padbytes,
    input  logic              udp_tx_data_rdy
);

    localparam int unsigned BYTES_PER_FLIT = DATA_W / 8;
    localparam int unsigned NUM_FLITS = (SC_MSG_BYTES + BYTES_PER_FLIT - 1) / BYTES_PER_FLIT;
    localparam int unsigned MSG_W     = SC_MSG_BYTES * 8;
    localparam int unsigned BUF_W     = NUM_FLITS * DATA_W;
    localparam int unsigned CNT_W     = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
    localparam int unsigned LAST_PAD  = NUM_FLITS * BYTES_PER_FLIT - SC_MSG_BYTES;

    sc_fmt_state_e    state_q, state_d;
    logic [CNT_W-1:0] flit_cnt_q, flit_cnt_d;
    logic [63:0]      view_q, view_d;
    logic [31:0]      idx_q, idx_d;
    config_entry_t    dst_q, dst_d;

    // Each request is exactly one beat, so the sequencer's last flag carries no
    // information here.
    logic unused_data_last;
    assign unused_data_last = start_change_to_udp_data_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            flit_cnt_q <= '0;
            view_q     <= '0;
            idx_q      <= '0;
            dst_q      <= '0;
        end else begin
            state_q    <= state_d;
            flit_cnt_q <= flit_cnt_d;
            view_q     <= view_d;
            idx_q      <= idx_d;
            dst_q      <= dst_d;
        end
    end

    // Destination loads in any state; an in-flight meta beat still shows the
    // old value because the outputs come straight from dst_q.
    always_comb begin
        dst_d = dst_q;
        if (store_config_ram_rd) begin
            dst_d = config_entry_t'(config_ram_rd_resp_data);
        end
    end

    always_comb begin
        state_d                      = state_q;
        flit_cnt_d                   = flit_cnt_q;
        view_d                       = view_q;
        idx_d                        = idx_q;
        to_udp_start_change_meta_rdy = 1'b0;
        to_udp_start_change_data_rdy = 1'b0;
        udp_tx_meta_val              = 1'b0;
        udp_tx_data_val              = 1'b0;

        unique case (state_q)
            StIdle: begin
                to_udp_start_change_meta_rdy = 1'b1;
                if (start_change_to_udp_meta_val) begin
                    view_d  = curr_view;
                    idx_d   = my_index;
                    state_d = StDataIn;
                end
            end
            StDataIn: begin
                to_udp_start_change_data_rdy = 1'b1;
                if (start_change_to_udp_data_val) begin
                    state_d = StOutMeta;
                end
            end
            StOutMeta: begin
                udp_tx_meta_val = 1'b1;
                if (udp_tx_meta_rdy) begin
                    flit_cnt_d = '0;
                    state_d    = StOutData;
                end
            end
            StOutData: begin
                udp_tx_data_val = 1'b1;
                if (udp_tx_data_rdy) begin
                    if (flit_cnt_q == CNT_W'(NUM_FLITS - 1)) begin
                        state_d = StIdle;
                    end else begin
                        flit_cnt_d = flit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d                      = sc_fmt_state_e'('x);
                flit_cnt_d                   = 'x;
                to_udp_start_change_meta_rdy = 1'bx;
                to_udp_start_change_data_rdy = 1'bx;
                udp_tx_meta_val              = 1'bx;
                udp_tx_data_val              = 1'bx;
            end
        endcase
    end

    assign udp_tx_meta_src_ip   = src_ip;
    assign udp_tx_meta_src_port = src_port;
    assign udp_tx_meta_dst_ip   = dst_q.ip;
    assign udp_tx_meta_dst_port = dst_q.port;
    assign udp_tx_meta_len      = 16'(SC_MSG_BYTES);

    sc_msg_hdr_t       msg_hdr;
    logic [BUF_W-1:0]  msg_buf;
    int unsigned       flit_sel;

    assign msg_hdr.msg_type    = SC_MSG_TYPE;
    assign msg_hdr.view        = view_q;
    assign msg_hdr.replica_idx = idx_q;

    // Message is left-justified in the flit buffer so byte 0 sits in the MSBs
    // of flit 0 and any padding is zero in the low bytes of the last flit.
    always_comb begin
        msg_buf                    = '0;
        msg_buf[BUF_W-1 -: MSG_W]  = msg_hdr;
        flit_sel                   = NUM_FLITS - 1 - int'(flit_cnt_q);
        udp_tx_data                = msg_buf[flit_sel * DATA_W +: DATA_W];
    end

    assign udp_tx_data_last     = udp_tx_data_val && (flit_cnt_q == CNT_W'(NUM_FLITS - 1));
    assign udp_tx_data_padbytes = udp_tx_data_last ? PAD_W'(LAST_PAD) : '0;

endmodule

// File: tb/tb_start_change_udp_formatter.sv
// Directed bench for start_change_udp_formatter: a DATA_W=64 instance carries
// most of the traffic, a DATA_W=256 instance checks single-flit formatting.
module tb_start_change_udp_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] src_ip;
    logic [15:0] src_port;
    logic [63:0] curr_view;
    logic [31:0] my_index;
    logic [47:0] config_ram_rd_resp_data;
    logic        store_config_ram_rd;

    // DATA_W = 64 instance
    logic        mv, dv, dlast, mr, dr;
    logic        meta_rdy, data_rdy, meta_val, data_val, data_last;
    logic [31:0] src_ip_o, dst_ip_o;
    logic [15:0] src_port_o, dst_port_o, len_o;
    logic [63:0] data_o;
    logic [2:0]  pad_o;

    // DATA_W = 256 instance
    logic         b_mv, b_dv, b_mr, b_dr;
    logic         b_meta_rdy, b_data_rdy, b_meta_val, b_data_val, b_data_last;
    logic [31:0]  b_src_ip_o, b_dst_ip_o;
    logic [15:0]  b_src_port_o, b_dst_port_o, b_len_o;
    logic [255:0] b_data_o;
    logic [4:0]   b_pad_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    start_change_udp_formatter #(.DATA_W(64)) u_dut (
        .clk                           (clk),
        .rst                           (rst),
        .src_ip                        (src_ip),
        .src_port                      (src_port),
        .curr_view                     (curr_view),
        .my_index                      (my_index),
        .config_ram_rd_resp_data       (config_ram_rd_resp_data),
        .store_config_ram_rd           (store_config_ram_rd),
        .start_change_to_udp_meta_val  (mv),
        .to_udp_start_change_meta_rdy  (meta_rdy),
        .start_change_to_udp_data_val  (dv),
        .start_change_to_udp_data_last (dlast),
        .to_udp_start_change_data_rdy  (data_rdy),
        .udp_tx_meta_val               (meta_val),
        .udp_tx_meta_src_ip            (src_ip_o),
        .udp_tx_meta_dst_ip            (dst_ip_o),
        .udp_tx_meta_src_port          (src_port_o),
        .udp_tx_meta_dst_port          (dst_port_o),
        .udp_tx_meta_len               (len_o),
        .udp_tx_meta_rdy               (mr),
        .udp_tx_data_val               (data_val),
        .udp_tx_data                   (data_o),
        .udp_tx_data_last              (data_last),
        .udp_tx_data_padbytes          (pad_o),
        .udp_tx_data_rdy               (dr)
    );

    start_change_udp_formatter #(.DATA_W(256)) u_dut256 (
        .clk                           (clk),
        .rst                           (rst),
        .src_ip                        (src_ip),
        .src_port                      (src_port),
        .curr_view                     (curr_view),
        .my_index                      (my_index),
        .config_ram_rd_resp_data       (config_ram_rd_resp_data),
        .store_config_ram_rd           (store_config_ram_rd),
        .start_change_to_udp_meta_val  (b_mv),
        .to_udp_start_change_meta_rdy  (b_meta_rdy),
        .start_change_to_udp_data_val  (b_dv),
        .start_change_to_udp_data_last (dlast),
        .to_udp_start_change_data_rdy  (b_data_rdy),
        .udp_tx_meta_val               (b_meta_val),
        .udp_tx_meta_src_ip            (b_src_ip_o),
        .udp_tx_meta_dst_ip            (b_dst_ip_o),
        .udp_tx_meta_src_port          (b_src_port_o),
        .udp_tx_meta_dst_port          (b_dst_port_o),
        .udp_tx_meta_len               (b_len_o),
        .udp_tx_meta_rdy               (b_mr),
        .udp_tx_data_val               (b_data_val),
        .udp_tx_data                   (b_data_o),
        .udp_tx_data_last              (b_data_last),
        .udp_tx_data_padbytes          (b_pad_o),
        .udp_tx_data_rdy               (b_dr)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [255:0] exp256;

    initial begin
        rst = 1'b1;
        src_ip = 32'hC0A8_0001;
        src_port = 16'h1234;
        curr_view = 64'd0;
        my_index = 32'd0;
        config_ram_rd_resp_data = '0;
        store_config_ram_rd = 1'b0;
        mv = 0; dv = 0; dlast = 1; mr = 1; dr = 1;
        b_mv = 0; b_dv = 0; b_mr = 1; b_dr = 1;
        step(); step();
        rst = 1'b0;

        // Reset state
        chk("rst_meta_rdy", 256'(meta_rdy), 256'(1));
        chk("rst_data_rdy", 256'(data_rdy), 256'(0));
        chk("rst_meta_val", 256'(meta_val), 256'(0));
        chk("rst_data_val", 256'(data_val), 256'(0));
        chk("rst_dst_ip", 256'(dst_ip_o), 256'(0));

        // Message 1: 10.0.0.2:8080, view 7, index 1, no backpressure
        config_ram_rd_resp_data = {32'h0A00_0002, 16'h1F90};
        store_config_ram_rd = 1'b1;
        step();
        store_config_ram_rd = 1'b0;
        curr_view = 64'd7;
        my_index = 32'd1;
        mv = 1;
        step();
        mv = 0;
        chk("m1_data_rdy", 256'(data_rdy), 256'(1));
        chk("m1_meta_rdy_low", 256'(meta_rdy), 256'(0));
        dv = 1;
        step();
        dv = 0;
        chk("m1_meta_val", 256'(meta_val), 256'(1));
        chk("m1_dst_ip", 256'(dst_ip_o), 256'(32'h0A00_0002));
        chk("m1_dst_port", 256'(dst_port_o), 256'(16'h1F90));
        chk("m1_src_ip", 256'(src_ip_o), 256'(32'hC0A8_0001));
        chk("m1_src_port", 256'(src_port_o), 256'(16'h1234));
        chk("m1_len", 256'(len_o), 256'(16));
        step();
        chk("m1_f0_val", 256'(data_val), 256'(1));
        chk("m1_f0_data", 256'(data_o), 256'(64'h0000_0005_0000_0000));
        chk("m1_f0_last", 256'(data_last), 256'(0));
        step();
        chk("m1_f1_data", 256'(data_o), 256'(64'h0000_0007_0000_0001));
        chk("m1_f1_last", 256'(data_last), 256'(1));
        chk("m1_f1_pad", 256'(pad_o), 256'(0));
        step();
        chk("m1_done_meta_rdy", 256'(meta_rdy), 256'(1));
        chk("m1_done_data_val", 256'(data_val), 256'(0));

        // Message 2: view changes after accept, meta backpressure, config update
        // coinciding with the meta handshake, toggling data ready.
        mr = 0;
        dr = 0;
        mv = 1;
        step();
        mv = 0;
        curr_view = 64'd8;
        dv = 1;
        step();
        dv = 0;
        for (int i = 0; i < 5; i++) begin
            chk("m2_meta_hold_val", 256'(meta_val), 256'(1));
            chk("m2_meta_hold_dst", 256'(dst_ip_o), 256'(32'h0A00_0002));
            step();
        end
        mr = 1;
        config_ram_rd_resp_data = {32'h0A00_0003, 16'h1F91};
        store_config_ram_rd = 1'b1;
        chk("m2_meta_old_dst_ip", 256'(dst_ip_o), 256'(32'h0A00_0002));
        chk("m2_meta_old_dst_port", 256'(dst_port_o), 256'(16'h1F90));
        step();
        store_config_ram_rd = 1'b0;
        mr = 1;
        chk("m2_meta_dropped", 256'(meta_val), 256'(0));
        chk("m2_f0_data_a", 256'(data_o), 256'(64'h0000_0005_0000_0000));
        step();
        chk("m2_f0_hold_val", 256'(data_val), 256'(1));
        chk("m2_f0_data_b", 256'(data_o), 256'(64'h0000_0005_0000_0000));
        dr = 1;
        step();
        dr = 0;
        chk("m2_f1_data_a", 256'(data_o), 256'(64'h0000_0007_0000_0001));
        step();
        chk("m2_f1_hold", 256'(data_o), 256'(64'h0000_0007_0000_0001));
        chk("m2_f1_last", 256'(data_last), 256'(1));
        dr = 1;
        step();
        chk("m2_done_data_val", 256'(data_val), 256'(0));
        chk("m2_done_meta_rdy", 256'(meta_rdy), 256'(1));

        // Message 3: picks up the new destination and view 8
        mv = 1;
        step();
        mv = 0;
        dv = 1;
        step();
        dv = 0;
        chk("m3_dst_ip", 256'(dst_ip_o), 256'(32'h0A00_0003));
        chk("m3_dst_port", 256'(dst_port_o), 256'(16'h1F91));
        step();
        chk("m3_f0_data", 256'(data_o), 256'(64'h0000_0005_0000_0000));
        step();
        chk("m3_f1_data", 256'(data_o), 256'(64'h0000_0008_0000_0001));
        step();
        chk("m3_done", 256'(meta_rdy), 256'(1));

        // Message 4: reset after flit0 is taken; flit1 is never accepted
        my_index = 32'd2;
        mv = 1;
        step();
        mv = 0;
        dv = 1;
        step();
        dv = 0;
        step();
        chk("m4_f0_val", 256'(data_val), 256'(1));
        step();
        chk("m4_f1_presented", 256'(data_o), 256'(64'h0000_0008_0000_0002));
        dr = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        dr = 1;
        chk("m4_rst_meta_rdy", 256'(meta_rdy), 256'(1));
        chk("m4_rst_data_val", 256'(data_val), 256'(0));
        chk("m4_rst_dst_cleared", 256'(dst_ip_o), 256'(0));
        step();
        chk("m4_no_flit1", 256'(data_val), 256'(0));

        // Message 5: clean message after reset
        config_ram_rd_resp_data = {32'h0A00_0002, 16'h1F90};
        store_config_ram_rd = 1'b1;
        curr_view = 64'd7;
        my_index = 32'd1;
        step();
        store_config_ram_rd = 1'b0;
        mv = 1;
        step();
        mv = 0;
        dv = 1;
        step();
        dv = 0;
        chk("m5_dst_ip", 256'(dst_ip_o), 256'(32'h0A00_0002));
        step();
        chk("m5_f0_data", 256'(data_o), 256'(64'h0000_0005_0000_0000));
        step();
        chk("m5_f1_data", 256'(data_o), 256'(64'h0000_0007_0000_0001));
        chk("m5_f1_last", 256'(data_last), 256'(1));
        step();

        // DATA_W = 256: single flit, 16 pad bytes, low bytes zero
        exp256 = {32'h0000_0005, 64'd7, 32'd1, 128'd0};
        chk("w256_idle_rdy", 256'(b_meta_rdy), 256'(1));
        b_mv = 1;
        step();
        b_mv = 0;
        b_dv = 1;
        step();
        b_dv = 0;
        chk("w256_meta_val", 256'(b_meta_val), 256'(1));
        chk("w256_dst_port", 256'(b_dst_port_o), 256'(16'h1F90));
        chk("w256_len", 256'(b_len_o), 256'(16));
        step();
        chk("w256_data_val", 256'(b_data_val), 256'(1));
        chk("w256_data", b_data_o, exp256);
        chk("w256_last", 256'(b_data_last), 256'(1));
        chk("w256_pad", 256'(b_pad_o), 256'(16));
        step();
        chk("w256_done_val", 256'(b_data_val), 256'(0));
        chk("w256_done_rdy", 256'(b_meta_rdy), 256'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
